// File: rtl/popcount_arbiter.sv
// Round-robin sequencer sharing one go/done popcount engine among NUM_REQ requesters.
// Optional watchdog on the engine handshake: define POPCOUNT_ARB_TIMEOUT_EN.
module popcount_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int CW      = $clog2(WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [CW-1:0]              result,
  output logic                       busy,
  output logic                       eng_go,
  output logic [WIDTH-1:0]           eng_data,
  input  logic                       eng_done,
  input  logic [CW-1:0]              eng_count,
  output logic                       err
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t             state_q;
  logic [PW-1:0]      ptr_q, gnt_q, pick_d, idx_w;
  logic               found_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [CW-1:0]      res_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               busy_q, go_q;
  int unsigned        idx;

`ifdef POPCOUNT_ARB_TIMEOUT_EN
  localparam int WD_LIMIT = 2 * WIDTH + 4;
  localparam int WDW      = $clog2(WD_LIMIT + 1);
  logic [WDW-1:0] wd_q;
  logic           err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // First pending requester at or after ptr_q, searching upward with wrap.
  always_comb begin
    found_d = 1'b0;
    pick_d  = '0;
    op_d    = '0;
    idx     = '0;
    idx_w   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx -= NUM_REQ;
      idx_w = idx[PW-1:0];
      if (!found_d && req[idx_w]) begin
        found_d = 1'b1;
        pick_d  = idx_w;
        op_d    = req_data[idx_w*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
`ifdef POPCOUNT_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      go_q  <= 1'b0;
      ack_q <= '0;
`ifdef POPCOUNT_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (found_d) begin
            gnt_q   <= pick_d;
            op_q    <= op_d;
            go_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef POPCOUNT_ARB_TIMEOUT_EN
          wd_q    <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            res_q        <= eng_count;
            ack_q[gnt_q] <= 1'b1;
            state_q      <= RESPOND;
          end
`ifdef POPCOUNT_ARB_TIMEOUT_EN
          else if (wd_q == WDW'(WD_LIMIT - 1)) begin
            res_q        <= '1;
            ack_q[gnt_q] <= 1'b1;
            err_q        <= 1'b1;
            state_q      <= RESPOND;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        RESPOND: begin
          ptr_q   <= (32'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign result   = res_q;
  assign busy     = busy_q;
  assign eng_go   = go_q;
  assign eng_data = op_q;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Bench for popcount_arbiter: behavioural popcount engine, scoreboard queue, ack monitor.
module tb_popcount_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk, rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [3:0]     result;
  logic           busy, eng_go, eng_done, err;
  logic [W-1:0]   eng_data;
  logic [3:0]     eng_count;

  int tests = 0;
  int fails = 0;

  typedef struct { int idx; int res; bit err; } exp_t;
  exp_t sbq[$];

  popcount_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .result(result), .busy(busy), .eng_go(eng_go), .eng_data(eng_data),
    .eng_done(eng_done), .eng_count(eng_count), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  // Engine model: zero check takes one cycle, then two cycles per set bit.
  logic       stuck;
  logic [4:0] tmr;

  function automatic int pc(input logic [W-1:0] d);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(d[i]);
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_done  <= 1'b0;
      eng_count <= '0;
      tmr       <= '0;
    end else if (eng_go) begin
      eng_done  <= 1'b0;
      eng_count <= 4'(pc(eng_data));
      tmr       <= stuck ? 5'd0 : 5'(1 + 2 * pc(eng_data));
    end else if (tmr != 0) begin
      tmr <= tmr - 1'b1;
      if (tmr == 5'd1) eng_done <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ack != '0) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          e = sbq.pop_front();
          chk("ack_onehot", 32'(ack), 32'(1) << e.idx);
          chk("result", 32'(result), 32'(e.res));
          chk("err_with_ack", 32'(err), 32'(e.err));
        end
      end else if (err !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL err_without_ack: got %b expected 0", err);
      end
    end
  end

  task automatic single_job(input int idx, input logic [W-1:0] d, input int exp_res,
                            input int exp_cyc, input bit exp_err);
    int  c;
    bit  got;
    req_data[idx*W +: W] = d;
    req[idx] = 1'b1;
    sbq.push_back('{idx, exp_res, exp_err});
    got = 1'b0;
    c   = 0;
    while (!got && c < 80) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        chk("eng_go_cycle1", 32'(eng_go), 1);
        chk("eng_data", 32'(eng_data), 32'(d));
        chk("busy_cycle1", 32'(busy), 1);
      end
      if (c == 2) chk("eng_go_one_cycle", 32'(eng_go), 0);
      if (ack[idx]) begin
        got = 1'b1;
        req[idx] = 1'b0;
      end
    end
    chk("ack_cycle", got ? 32'(c) : 32'hFFFF_FFFF, 32'(exp_cyc));
    chk("busy_at_ack", 32'(busy), 1);
    @(negedge clk);
    chk("busy_after_ack", 32'(busy), 0);
  endtask

  task automatic wait_ack(input int idx, input logic [N-1:0] keep);
    int c;
    bit got;
    c   = 0;
    got = 1'b0;
    while (!got && c < 200) begin
      @(negedge clk);
      c++;
      got = ack[idx];
      req = req & ~(ack & ~keep);
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: requester %0d got no ack, expected one", idx);
    end
  endtask

  task automatic pulse_reset();
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    stuck    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_eng_go", 32'(eng_go), 0);
    chk("rst_eng_data", 32'(eng_data), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero operand on requester 2: go at cycle 1, ack at cycle 4, ptr moves to 3.
    single_job(2, 8'h00, 0, 4, 1'b0);

    // With ptr at 3, simultaneous requests 0 and 3 grant 3 first.
    req_data[0*W +: W] = 8'h00;
    req_data[3*W +: W] = 8'h81;
    req = 4'b1001;
    sbq.push_back('{3, 2, 1'b0});
    sbq.push_back('{0, 0, 1'b0});
    wait_ack(3, '0);
    wait_ack(0, '0);
    @(negedge clk);

    // 8'hB5 has five set bits: ack at cycle 14.
    single_job(0, 8'hB5, 5, 14, 1'b0);

    // All four held from ptr 0: served 0,1,2,3.
    pulse_reset();
    req_data = {8'h0F, 8'h07, 8'h03, 8'h01};
    req = 4'b1111;
    sbq.push_back('{0, 1, 1'b0});
    sbq.push_back('{1, 2, 1'b0});
    sbq.push_back('{2, 3, 1'b0});
    sbq.push_back('{3, 4, 1'b0});
    for (int i = 0; i < N; i++) wait_ack(i, '0);
    @(negedge clk);

    // Fairness: requester 1 holds through its ack, 3 arrives mid-job; order 1,3,1.
    req_data[1*W +: W] = 8'h03;
    req_data[3*W +: W] = 8'hFF;
    req = 4'b0010;
    sbq.push_back('{1, 2, 1'b0});
    sbq.push_back('{3, 8, 1'b0});
    sbq.push_back('{1, 2, 1'b0});
    repeat (3) @(negedge clk);
    req[3] = 1'b1;
    wait_ack(1, 4'b0010);
    wait_ack(3, '0);
    wait_ack(1, '0);
    @(negedge clk);

    // Asynchronous reset in mid-WAIT aborts the job with no ack.
    req_data[2*W +: W] = 8'hFF;
    req[2] = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    req = '0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_eng_go", 32'(eng_go), 0);
    chk("mid_rst_eng_data", 32'(eng_data), 0);
    chk("mid_rst_result", 32'(result), 0);
    chk("mid_rst_err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 0);
    single_job(1, 8'h0F, 4, 12, 1'b0);

`ifdef POPCOUNT_ARB_TIMEOUT_EN
    // Engine never answers: 20 WAIT cycles, then ack with all-ones result and err.
    stuck = 1'b1;
    single_job(0, 8'h55, 15, 22, 1'b1);
    stuck = 1'b0;
`endif

    c = 0;
    while (sbq.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("scoreboard_drained", 32'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
